fb_write_scheduler: RTL and testbench
=====================================

Name: fb_write_scheduler

Overview:
Owns the single write port of the frameRAM frame buffer (320 words per line, 480 lines, two 4-bit colour enums per 16-bit word in [3:0] and [11:8]). Shares that port between the blue and red trail writers with round-robin arbitration. Also runs a full-screen clear engine that fills the buffer with the background enum at the start of each round. Sits between the game-logic trail writers and the frame buffer; the display read path is untouched.

Parameters:
WORDS, 153600, number of frame-buffer words (320 x 480)
CLEAR_WORD, 16'h0808, word written by the clear engine (background enum 8 in both pixel nibbles)
ADDR_W, 19, write-address width

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
clear_start  in  1  one-cycle pulse; begin or restart a full-screen clear
clear_busy  out  1  high while the clear engine owns the port
clear_done  out  1  one-cycle pulse after the last clear word is written
blue_req  in  1  blue trail write request; held until blue_ack
blue_addr  in  ADDR_W  blue word address, held with blue_req
blue_data  in  16  blue word data, held with blue_req
blue_ack  out  1  one-cycle pulse; blue request consumed
red_req  in  1  red trail write request; held until red_ack
red_addr  in  ADDR_W  red word address
red_data  in  16  red word data
red_ack  out  1  one-cycle pulse; red request consumed
WE  out  1  frame-buffer write enable
write_address  out  ADDR_W  frame-buffer write address
Data_In  out  16  frame-buffer write data

Behaviour:
- All outputs are registered. Reset values:
  - WE=0, write_address=0, Data_In=0.
  - blue_ack=0, red_ack=0.
  - clear_busy=0, clear_done=0.
  - state=SERVE, clear counter=0, round-robin pointer=RED (so blue wins the first tie).
- State SERVE:
  - A requester is eligible in cycle N if its req=1 and its ack=0 in cycle N. This prevents a double grant on a still-held req.
  - If one requester is eligible, grant it. If both are eligible, grant the one not granted last, then flip the pointer.
  - Cycle N+1: WE=1, write_address/Data_In = the granted addr/data, and the granted ack=1.
  - Latency from req to write is 1 cycle.
  - A single continuous requester gets one write every 2 cycles. Two continuous requesters alternate B,R,B,R at one write per cycle.
- Granted address >= WORDS: ack is still issued, but WE=0 that cycle (the write is dropped).
- clear_start=1 in any state:
  - Next cycle: state=CLEAR, clear_busy=1, counter=0. No grant is issued that cycle.
  - clear_start has priority over both requesters.
- State CLEAR:
  - Each cycle: WE=1, write_address=counter, Data_In=CLEAR_WORD, counter++.
  - No acks are issued; pending reqs stay held.
  - After the write of address WORDS-1: the next cycle has clear_busy=0, clear_done=1 for 1 cycle, WE=0, state=SERVE. Arbitration resumes the cycle after that.
  - Total: WORDS write cycles. clear_done falls WORDS+1 cycles after the clear_start cycle.
- clear_start during CLEAR restarts the counter at 0; there is no done pulse for the aborted pass.
- Reset mid-clear aborts the clear: no clear_done, and all outputs return to reset values next cycle.
- Counter width is ADDR_W. It never wraps, because it stops at WORDS-1.
- WE is 0 in every cycle in which no write is scheduled.

Test Plan:
- Reset asserted 2 cycles -> all outputs 0; first clear_start after release -> WE=1, write_address=0, Data_In=16'h0808 next cycle; clear_done pulses exactly 153601 cycles after clear_start, with exactly 153600 WE cycles covering addresses 0..153599 once.
- blue_req with addr=19'd1000, data=16'h0303, held until ack -> next cycle WE=1, write_address=1000, Data_In=16'h0303, blue_ack=1; no second write while req is dropped in the following cycle.
- blue_req and red_req both held for 8 cycles with distinct addrs -> grants alternate B,R,B,R starting with blue; each ack exactly once per request; WE high every cycle.
- red_req held while clear_start pulses, then clear runs (use WORDS=16 build) -> red_ack=0 throughout clear; red write occurs on the first cycle after clear_done.
- clear_start repulsed at counter=8 (WORDS=16) -> write_address returns to 0 next cycle, single clear_done at the end; Reset at counter=5 -> no clear_done, clear_busy=0 next cycle.
- blue_req with addr=19'd153600 -> blue_ack=1, WE=0 in that cycle.

Source files
------------

// File: rtl/fb_write_scheduler.sv
// Single write-port owner for the frameRAM frame buffer: round-robin blue/red trail writes
// plus a full-screen clear engine that fills the buffer with the background word.
module fb_write_scheduler #(
  parameter int unsigned WORDS      = 153600,
  parameter logic [15:0] CLEAR_WORD = 16'h0808,
  parameter int unsigned ADDR_W     = 19
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              blue_req,
  input  logic [ADDR_W-1:0] blue_addr,
  input  logic [15:0]       blue_data,
  output logic              blue_ack,
  input  logic              red_req,
  input  logic [ADDR_W-1:0] red_addr,
  input  logic [15:0]       red_data,
  output logic              red_ack,
  output logic              WE,
  output logic [ADDR_W-1:0] write_address,
  output logic [15:0]       Data_In
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  typedef enum logic {SERVE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_red_q, last_red_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              blue_ack_q, blue_ack_d;
  logic              red_ack_q, red_ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              blue_elig, red_elig;
  logic              grant_blue, grant_red;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= SERVE;
      cnt_q      <= '0;
      last_red_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      blue_ack_q <= 1'b0;
      red_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_red_q <= last_red_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      blue_ack_q <= blue_ack_d;
      red_ack_q  <= red_ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // A request still showing its ack was already consumed last cycle, so it is not eligible again.
  always_comb begin
    blue_elig  = blue_req & ~blue_ack_q;
    red_elig   = red_req & ~red_ack_q;
    grant_blue = blue_elig & (~red_elig | last_red_q);
    grant_red  = red_elig & ~grant_blue;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_red_d = last_red_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    blue_ack_d = 1'b0;
    red_ack_d  = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (clear_start) begin
      state_d = CLEAR;
      cnt_d   = '0;
      busy_d  = 1'b1;
      we_d    = 1'b1;
      addr_d  = '0;
      data_d  = CLEAR_WORD;
    end else if (state_q == CLEAR) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = SERVE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        cnt_d  = cnt_q + ADDR_W'(1);
        we_d   = 1'b1;
        addr_d = cnt_q + ADDR_W'(1);
        data_d = CLEAR_WORD;
      end
    end else if (grant_blue) begin
      blue_ack_d = 1'b1;
      last_red_d = 1'b0;
      addr_d     = blue_addr;
      data_d     = blue_data;
      we_d       = (blue_addr <= LAST_ADDR);
    end else if (grant_red) begin
      red_ack_d  = 1'b1;
      last_red_d = 1'b1;
      addr_d     = red_addr;
      data_d     = red_data;
      we_d       = (red_addr <= LAST_ADDR);
    end
  end

  assign WE            = we_q;
  assign write_address = addr_q;
  assign Data_In       = data_q;
  assign blue_ack      = blue_ack_q;
  assign red_ack       = red_ack_q;
  assign clear_busy    = busy_q;
  assign clear_done    = done_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler: a 16-word build for arbitration and clear sequencing,
// plus a full-size build for the real address range.
module tb_fb_write_scheduler;

  logic        clk;
  logic        reset;
  logic        clearStart, clearBusy, clearDone;
  logic        blueReq, blueAck, redReq, redAck;
  logic [18:0] blueAddr, redAddr, writeAddress;
  logic [15:0] blueData, redData, dataIn;
  logic        we;

  logic        fClearStart, fClearBusy, fClearDone;
  logic        fBlueReq, fBlueAck, fRedReq, fRedAck;
  logic [18:0] fBlueAddr, fRedAddr, fWriteAddress;
  logic [15:0] fBlueData, fRedData, fDataIn;
  logic        fWe;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;

  typedef struct packed {
    logic [18:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic        bReq;
    logic [18:0] bAddr;
    logic [15:0] bData;
    logic        rReq;
    logic [18:0] rAddr;
    logic [15:0] rData;
    logic        expWe;
    logic [18:0] expAddr;
    logic [15:0] expData;
    logic        expBack;
    logic        expRack;
  } vec_t;
  vec_t vecs[23];

  fb_write_scheduler #(.WORDS(16)) dut (
    .Clk(clk), .Reset(reset),
    .clear_start(clearStart), .clear_busy(clearBusy), .clear_done(clearDone),
    .blue_req(blueReq), .blue_addr(blueAddr), .blue_data(blueData), .blue_ack(blueAck),
    .red_req(redReq), .red_addr(redAddr), .red_data(redData), .red_ack(redAck),
    .WE(we), .write_address(writeAddress), .Data_In(dataIn)
  );

  fb_write_scheduler dutFull (
    .Clk(clk), .Reset(reset),
    .clear_start(fClearStart), .clear_busy(fClearBusy), .clear_done(fClearDone),
    .blue_req(fBlueReq), .blue_addr(fBlueAddr), .blue_data(fBlueData), .blue_ack(fBlueAck),
    .red_req(fRedReq), .red_addr(fRedAddr), .red_data(fRedData), .red_ack(fRedAck),
    .WE(fWe), .write_address(fWriteAddress), .Data_In(fDataIn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic br, input int ba, input int bd,
                              input logic rr, input int ra, input int rd,
                              input logic ew, input int ea, input int ed,
                              input logic eb, input logic er);
    vec_t v;
    v.bReq = br; v.bAddr = 19'(ba); v.bData = 16'(bd);
    v.rReq = rr; v.rAddr = 19'(ra); v.rData = 16'(rd);
    v.expWe = ew; v.expAddr = 19'(ea); v.expData = 16'(ed);
    v.expBack = eb; v.expRack = er;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    blueReq  = v.bReq;
    blueAddr = v.bAddr;
    blueData = v.bData;
    redReq   = v.rReq;
    redAddr  = v.rAddr;
    redData  = v.rData;
    if (v.expWe) sb.push_back({v.expAddr, v.expData});
  endtask

  task automatic pushClear(input int first, input int last);
    for (int a = first; a <= last; a++) sb.push_back({19'(a), 16'h0808});
  endtask

  // Steps cycle by cycle after a clear pulse until clear_done or the budget runs out.
  task automatic runUntilDone(input int limit, output int cycles, output bit rackSeen);
    cycles = 0;
    rackSeen = 1'b0;
    do begin
      @(posedge clk); #2;
      clearStart = 1'b0;
      cycles++;
      if (redAck) rackSeen = 1'b1;
    end while (!clearDone && cycles < limit);
  endtask

  initial begin
    int cyc;
    bit rackSeen;
    int dc0;

    reset = 1'b1;
    clearStart = 0; blueReq = 0; redReq = 0;
    blueAddr = 0; blueData = 0; redAddr = 0; redData = 0;
    fClearStart = 0; fBlueReq = 0; fRedReq = 0;
    fBlueAddr = 0; fBlueData = 0; fRedAddr = 0; fRedData = 0;

    // Every write the small build makes must match the next scoreboard entry.
    fork
      forever begin
        @(negedge clk);
        if (clearDone) doneCount++;
        if (we) begin
          if (sb.size() == 0) begin
            checkOutput("spurious write", 32'(writeAddress), 32'h7FFFFFFF);
          end else begin
            wr_t expWr;
            expWr = sb.pop_front();
            checkOutput("sb write_address", 32'(writeAddress), 32'(expWr.addr));
            checkOutput("sb Data_In", 32'(dataIn), 32'(expWr.data));
          end
        end
      end
    join_none

    vecs[0]  = mk(1, 0, 'h1111, 1, 8, 'h2222,   1, 0, 'h1111, 1, 0);
    vecs[1]  = mk(1, 0, 'h1111, 1, 8, 'h2222,   1, 8, 'h2222, 0, 1);
    vecs[2]  = mk(1, 1, 'h1112, 1, 8, 'h2222,   1, 1, 'h1112, 1, 0);
    vecs[3]  = mk(1, 1, 'h1112, 1, 9, 'h2223,   1, 9, 'h2223, 0, 1);
    vecs[4]  = mk(1, 2, 'h1113, 1, 9, 'h2223,   1, 2, 'h1113, 1, 0);
    vecs[5]  = mk(1, 2, 'h1113, 1, 10, 'h2224,  1, 10, 'h2224, 0, 1);
    vecs[6]  = mk(1, 3, 'h1114, 1, 10, 'h2224,  1, 3, 'h1114, 1, 0);
    vecs[7]  = mk(1, 3, 'h1114, 1, 11, 'h2225,  1, 11, 'h2225, 0, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 5, 'h0505, 0, 0, 0,        1, 5, 'h0505, 1, 0);
    vecs[10] = mk(1, 5, 'h0505, 0, 0, 0,        0, 0, 0, 0, 0);
    vecs[11] = mk(1, 6, 'h0606, 0, 0, 0,        1, 6, 'h0606, 1, 0);
    vecs[12] = mk(1, 6, 'h0606, 0, 0, 0,        0, 0, 0, 0, 0);
    vecs[13] = mk(1, 7, 'h0707, 1, 13, 'h0D0D,  1, 13, 'h0D0D, 0, 1);
    vecs[14] = mk(1, 7, 'h0707, 1, 13, 'h0D0D,  1, 7, 'h0707, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0);
    vecs[16] = mk(1, 16, 'h0F0F, 0, 0, 0,       0, 0, 0, 1, 0);
    vecs[17] = mk(1, 16, 'h0F0F, 0, 0, 0,       0, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 1, 15, 'h0A0A,       1, 15, 'h0A0A, 0, 1);
    vecs[19] = mk(0, 0, 0, 1, 15, 'h0A0A,       0, 0, 0, 0, 0);
    vecs[20] = mk(1, 4, 'h0404, 1, 12, 'h0C0C,  1, 4, 'h0404, 1, 0);
    vecs[21] = mk(1, 4, 'h0404, 1, 12, 'h0C0C,  1, 12, 'h0C0C, 0, 1);
    vecs[22] = mk(0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset WE", 32'(we), 0);
    checkOutput("reset write_address", 32'(writeAddress), 0);
    checkOutput("reset Data_In", 32'(dataIn), 0);
    checkOutput("reset acks", 32'({blueAck, redAck}), 0);
    checkOutput("reset clear flags", 32'({clearBusy, clearDone}), 0);
    checkOutput("reset full WE/addr", 32'({fWe, fWriteAddress}), 0);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk); #2;
      checkOutput($sformatf("v%0d WE", i), 32'(we), 32'(vecs[i].expWe));
      checkOutput($sformatf("v%0d blue_ack", i), 32'(blueAck), 32'(vecs[i].expBack));
      checkOutput($sformatf("v%0d red_ack", i), 32'(redAck), 32'(vecs[i].expRack));
      if (vecs[i].expWe) begin
        checkOutput($sformatf("v%0d write_address", i), 32'(writeAddress), 32'(vecs[i].expAddr));
        checkOutput($sformatf("v%0d Data_In", i), 32'(dataIn), 32'(vecs[i].expData));
      end
    end

    // Red waits out a full clear and is written right after the done pulse.
    clearStart = 1'b1;
    redReq = 1'b1; redAddr = 19'd14; redData = 16'h0E0E;
    pushClear(0, 15);
    sb.push_back({19'd14, 16'h0E0E});
    @(posedge clk); #2;
    clearStart = 1'b0;
    checkOutput("clear first WE", 32'(we), 1);
    checkOutput("clear first address", 32'(writeAddress), 0);
    checkOutput("clear first busy", 32'(clearBusy), 1);
    runUntilDone(40, cyc, rackSeen);
    cyc = cyc + 1;
    checkOutput("clear_done latency", 32'(cyc), 17);
    checkOutput("red_ack during clear", 32'(rackSeen), 0);
    checkOutput("done cycle busy/WE", 32'({clearBusy, we}), 0);
    @(posedge clk); #2;
    checkOutput("red after clear ack", 32'(redAck), 1);
    checkOutput("red after clear WE", 32'(we), 1);
    redReq = 1'b0;
    @(posedge clk); #2;

    // Restart at counter 8: back to address 0, a single done pulse at the end.
    dc0 = doneCount;
    clearStart = 1'b1;
    pushClear(0, 8);
    repeat (9) begin
      @(posedge clk); #2;
      clearStart = 1'b0;
    end
    checkOutput("restart point address", 32'(writeAddress), 8);
    clearStart = 1'b1;
    pushClear(0, 15);
    @(posedge clk); #2;
    clearStart = 1'b0;
    checkOutput("restart address", 32'(writeAddress), 0);
    runUntilDone(40, cyc, rackSeen);
    checkOutput("restart done latency", 32'(cyc + 1), 17);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("restart done count", 32'(doneCount - dc0), 1);

    // Reset at counter 5 aborts the clear without a done pulse.
    dc0 = doneCount;
    clearStart = 1'b1;
    pushClear(0, 5);
    repeat (6) begin
      @(posedge clk); #2;
      clearStart = 1'b0;
    end
    checkOutput("abort point address", 32'(writeAddress), 5);
    reset = 1'b1;
    @(posedge clk); #2;
    checkOutput("abort busy/done/WE", 32'({clearBusy, clearDone, we}), 0);
    checkOutput("abort full dut busy", 32'(fClearBusy), 0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    checkOutput("abort no done", 32'(doneCount - dc0), 0);
    checkOutput("scoreboard drained", 32'(sb.size()), 0);

    // Full-size build: real address range and its boundary.
    fBlueReq = 1'b1; fBlueAddr = 19'd1000; fBlueData = 16'h0303;
    @(posedge clk); #2;
    checkOutput("full blue WE", 32'(fWe), 1);
    checkOutput("full blue address", 32'(fWriteAddress), 1000);
    checkOutput("full blue Data_In", 32'(fDataIn), 'h0303);
    checkOutput("full blue_ack", 32'(fBlueAck), 1);
    fBlueReq = 1'b0;
    @(posedge clk); #2;
    checkOutput("full no second write", 32'({fWe, fBlueAck}), 0);
    fBlueReq = 1'b1; fBlueAddr = 19'd153600; fBlueData = 16'h0F0F;
    @(posedge clk); #2;
    checkOutput("full oob ack", 32'(fBlueAck), 1);
    checkOutput("full oob WE", 32'(fWe), 0);
    fBlueReq = 1'b0;
    @(posedge clk); #2;
    fBlueReq = 1'b1; fBlueAddr = 19'd153599; fBlueData = 16'h0505;
    @(posedge clk); #2;
    checkOutput("full last word WE", 32'(fWe), 1);
    checkOutput("full last word address", 32'(fWriteAddress), 153599);
    fBlueReq = 1'b0;
    @(posedge clk); #2;
    fClearStart = 1'b1;
    @(posedge clk); #2;
    fClearStart = 1'b0;
    checkOutput("full clear WE", 32'(fWe), 1);
    checkOutput("full clear address", 32'(fWriteAddress), 0);
    checkOutput("full clear Data_In", 32'(fDataIn), 'h0808);
    checkOutput("full clear busy", 32'(fClearBusy), 1);
    @(posedge clk); #2;
    checkOutput("full clear second address", 32'(fWriteAddress), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
